// File: rtl/stack_seq_pkg.sv
// Shared opcode, FSM state and error-code definitions for the stack-machine sequencer.
// Pure definitions: no latency or flow control of its own.
// Imported by the sequencer top and its program memory.
package stack_seq_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_PUSH = 3'd4;
    localparam logic [2:0] OP_NEG  = 3'd5;
    localparam logic [2:0] OP_AND  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DONE,
        ST_ERROR
    } seq_state_t;

    // Ops that consume two stack entries and leave one behind.
    function automatic logic op_is_binary(logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/stack_seq_prog_mem.sv
// Program store: P x 3-bit opcode register file, one synchronous write port.
// Latency: write lands on the next clk edge; read is combinational by address.
// Backpressure: none; writes are always accepted when we is high.
module stack_seq_prog_mem #(
    parameter int P  = 16,
    parameter int AW = $clog2(P)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [2:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [2:0]    rd_data
);

    logic [2:0] mem [P];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stack_machine_sequencer.sv
// Opcode sequencer for the stack datapath; optional depth traps under STACK_SEQ_DEPTH_CHECK_EN.
// Latency: start -> one CLEAR cycle -> one op per RUN cycle -> done the cycle after the last op.
// Backpressure: PUSH stalls (NOP issued) until opnd_valid; opnd_ready marks the consuming cycle.
module stack_machine_sequencer
    import stack_seq_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int S  = 8,
    parameter  int P  = 16,
    localparam int AW = $clog2(P)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [2:0]    prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  opnd_data,
    input  logic          opnd_valid,
    output logic          opnd_ready,
    output logic [2:0]    dp_op,
    output logic [N-1:0]  dp_data,
    output logic          dp_clr,
    input  logic [N-1:0]  dp_top,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [N-1:0]  result
);

    seq_state_t    state;
    logic [AW-1:0] pc;
    logic [AW:0]   len_q;
    logic [2:0]    op;
    logic          capture;
    logic          trap;
    logic [1:0]    trap_code;
    logic          running;
    logic          issue;
    logic          last;
    logic          go_clear;

    stack_seq_prog_mem #(.P(P), .AW(AW)) u_prog_mem (
        .clk     (clk),
        .we      (prog_we && (state == ST_IDLE)),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (pc),
        .rd_data (op)
    );

`ifdef STACK_SEQ_DEPTH_CHECK_EN
    localparam int DW = $clog2(S + 1);
    logic [DW-1:0] depth;

    always_comb begin
        trap      = 1'b0;
        trap_code = ERR_NONE;
        if (op_is_binary(op) && depth < DW'(2)) begin
            trap      = 1'b1;
            trap_code = ERR_UNDERFLOW;
        end else if (op == OP_NEG && depth == '0) begin
            trap      = 1'b1;
            trap_code = ERR_UNDERFLOW;
        end else if (op == OP_PUSH && depth == DW'(S)) begin
            trap      = 1'b1;
            trap_code = ERR_OVERFLOW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth <= '0;
        end else if (go_clear) begin
            depth <= '0;
        end else if (issue) begin
            if (op == OP_PUSH) begin
                depth <= depth + DW'(1);
            end else if (op_is_binary(op)) begin
                depth <= depth - DW'(1);
            end
        end
    end
`else
    assign trap      = 1'b0;
    assign trap_code = ERR_NONE;
`endif

    // abort suppresses any issue in the cycle it is asserted.
    assign running    = (state == ST_RUN) && !abort;
    assign opnd_ready = running && (op == OP_PUSH) && !trap;
    assign issue      = running && !trap && ((op != OP_PUSH) || opnd_valid);
    assign dp_op      = issue ? op : OP_NOP;
    assign dp_data    = opnd_data;
    assign last       = ({1'b0, pc} == (len_q - (AW+1)'(1)));
    assign go_clear   = !abort && start && (prog_len != '0) &&
                        ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= '0;
            len_q    <= '0;
            dp_clr   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            result   <= '0;
            capture  <= 1'b0;
        end else begin
            dp_clr  <= 1'b0;
            capture <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
                err   <= 1'b0;
            end else begin
                // The datapath updates on the same edge as the last issue, so its
                // final top is only visible during the first DONE cycle.
                if (capture) begin
                    result <= dp_top;
                end
                if (go_clear) begin
                    state    <= ST_CLEAR;
                    len_q    <= prog_len;
                    pc       <= '0;
                    dp_clr   <= 1'b1;
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    err      <= 1'b0;
                    err_code <= ERR_NONE;
                end else if (state == ST_CLEAR) begin
                    state <= ST_RUN;
                end else if (state == ST_RUN) begin
                    if (trap) begin
                        state    <= ST_ERROR;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                        err_code <= trap_code;
                    end else if (issue) begin
                        pc <= pc + AW'(1);
                        if (last) begin
                            state   <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            capture <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stack_machine_sequencer.sv
// Directed bench for stack_machine_sequencer with a behavioural stack datapath attached.
module tb_stack_machine_sequencer;
    import stack_seq_pkg::*;

    localparam int N  = 8;
    localparam int S  = 8;
    localparam int P  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [2:0]    prog_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          abort;
    logic [N-1:0]  opnd_data;
    logic          opnd_valid;
    logic          opnd_ready;
    logic [2:0]    dp_op;
    logic [N-1:0]  dp_data;
    logic          dp_clr;
    logic [N-1:0]  dp_top;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [N-1:0]  result;

    stack_machine_sequencer #(.N(N), .S(S), .P(P)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start), .abort(abort),
        .opnd_data(opnd_data), .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
        .dp_op(dp_op), .dp_data(dp_data), .dp_clr(dp_clr), .dp_top(dp_top),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .result(result)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: stk[0] is top of stack; binary ops compute top (op) next.
    logic [N-1:0] stk [S];
    assign dp_top = stk[0];

    function automatic logic [N-1:0] bin_op(input logic [2:0] o, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        case (o)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_AND:  return a & b;
            default: return a | b;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst || dp_clr) begin
            for (int i = 0; i < S; i++) stk[i] <= '0;
        end else if (dp_op == OP_PUSH) begin
            for (int i = S - 1; i > 0; i--) stk[i] <= stk[i-1];
            stk[0] <= dp_data;
        end else if (dp_op == OP_NEG) begin
            stk[0] <= -stk[0];
        end else if (op_is_binary(dp_op)) begin
            stk[0] <= bin_op(dp_op, stk[0], stk[1]);
            for (int i = 1; i < S - 1; i++) stk[i] <= stk[i+1];
            stk[S-1] <= '0;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0][2:0] prog;
        int               len;
        logic [9:0][7:0]  opnd;
        int               nopnd;
        int               stall_idx;
        int               stall_n;
        bit               start_mid;
        int               exp_cycle;
        logic [7:0]       exp_result;
        logic [1:0]       exp_err;
        int               exp_hs;
        logic [2:0]       forbid;
    } vec_t;

    localparam int NV = 9;
    vec_t vec [NV];

    task automatic load(input vec_t v);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < v.len; i++) begin
            prog_we   = 1'b1;
            prog_addr = AW'(i);
            prog_data = v.prog[i];
            @(negedge clk);
        end
        prog_we = 1'b0;
    endtask

    // Starts at a negedge; edge 0 is the following posedge.
    task automatic run(input vec_t v, input string nm);
        int opi        = 0;
        int hs         = 0;
        int stall_left = v.stall_n;
        int end_cyc    = 0;
        bit forbid_seen = 0;
        bit stall_bad   = 0;
        bit stalled;
        prog_len = (AW+1)'(v.len);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            stalled    = (opi == v.stall_idx) && (stall_left > 0);
            opnd_valid = (opi < v.nopnd) && !stalled;
            opnd_data  = v.opnd[(opi < 10) ? opi : 0];
            start      = v.start_mid && (cyc == 3);
            #1;
            if (cyc == 1) check({nm, " dp_clr pulse"}, 32'(dp_clr), 32'd1);
            if (cyc == 2) check({nm, " dp_clr low"}, 32'(dp_clr), 32'd0);
            if (v.forbid != OP_NOP && dp_op == v.forbid) forbid_seen = 1;
            if (opnd_valid && opnd_ready) begin
                hs++;
                opi++;
                if (dp_data !== opnd_data || dp_op !== OP_PUSH) stall_bad = 1;
            end else if (stalled && opnd_ready) begin
                stall_left--;
                if (dp_op !== OP_NOP) stall_bad = 1;
            end
            if (done || err) begin
                end_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        start      = 1'b0;
        opnd_valid = 1'b0;
        check({nm, " end cycle"}, 32'(end_cyc), 32'(v.exp_cycle));
        check({nm, " err_code"}, 32'(err_code), 32'(v.exp_err));
        check({nm, " done level"}, 32'(done), 32'(v.exp_err == ERR_NONE));
        check({nm, " handshakes"}, 32'(hs), 32'(v.exp_hs));
        check({nm, " push/stall issue"}, 32'(stall_bad), 32'd0);
        if (v.forbid != OP_NOP) check({nm, " trapped op issued"}, 32'(forbid_seen), 32'd0);
        @(negedge clk);
        #1;
        check({nm, " busy after"}, 32'(busy), 32'd0);
        check({nm, " dp_op idle"}, 32'(dp_op), 32'(OP_NOP));
        if (v.exp_err == ERR_NONE) check({nm, " result"}, 32'(result), 32'(v.exp_result));
    endtask

    initial begin
        rst = 1'b1; prog_we = 0; prog_addr = '0; prog_data = '0; prog_len = '0;
        start = 0; abort = 0; opnd_data = '0; opnd_valid = 0;

        for (int i = 0; i < NV; i++) begin
            vec[i] = '0;
            vec[i].stall_idx = -1;
        end
        vec[0].prog[0] = OP_PUSH; vec[0].prog[1] = OP_PUSH; vec[0].prog[2] = OP_SUB;
        vec[0].len = 3; vec[0].opnd[0] = 8'd3; vec[0].opnd[1] = 8'd5; vec[0].nopnd = 2;
        vec[0].exp_cycle = 5; vec[0].exp_result = 8'd2; vec[0].exp_hs = 2;

        vec[1].prog[0] = OP_PUSH; vec[1].prog[1] = OP_PUSH; vec[1].prog[2] = OP_MUL;
        vec[1].prog[3] = OP_NEG; vec[1].len = 4;
        vec[1].opnd[0] = 8'hFC; vec[1].opnd[1] = 8'd6; vec[1].nopnd = 2;
        vec[1].exp_cycle = 6; vec[1].exp_result = 8'd24; vec[1].exp_hs = 2;

        vec[2] = vec[0]; vec[2].stall_idx = 1; vec[2].stall_n = 3; vec[2].exp_cycle = 8;

        vec[3].prog[0] = OP_PUSH; vec[3].prog[1] = OP_ADD; vec[3].len = 2;
        vec[3].opnd[0] = 8'd5; vec[3].nopnd = 1; vec[3].exp_cycle = 4; vec[3].exp_hs = 1;
`ifdef STACK_SEQ_DEPTH_CHECK_EN
        vec[3].exp_err = ERR_UNDERFLOW; vec[3].forbid = OP_ADD;
`else
        vec[3].exp_result = 8'd5;
`endif

        for (int i = 0; i < 9; i++) begin
            vec[4].prog[i] = OP_PUSH;
            vec[4].opnd[i] = 8'(i + 1);
        end
        vec[4].len = 9; vec[4].nopnd = 9; vec[4].exp_cycle = 11;
`ifdef STACK_SEQ_DEPTH_CHECK_EN
        vec[4].exp_err = ERR_OVERFLOW; vec[4].exp_hs = 8;
`else
        vec[4].exp_result = 8'd9; vec[4].exp_hs = 9;
`endif

        vec[5] = vec[0]; vec[5].prog[2] = OP_AND;
        vec[5].opnd[0] = 8'd12; vec[5].opnd[1] = 8'd10; vec[5].exp_result = 8'd8;

        vec[6] = vec[1]; vec[6].prog[2] = OP_OR;
        vec[6].opnd[0] = 8'd12; vec[6].opnd[1] = 8'd3; vec[6].exp_result = 8'hF1;

        vec[7].prog[0] = OP_PUSH; vec[7].prog[1] = OP_NOP; vec[7].prog[2] = OP_PUSH;
        vec[7].prog[3] = OP_ADD; vec[7].len = 4;
        vec[7].opnd[0] = 8'd7; vec[7].opnd[1] = 8'hFE; vec[7].nopnd = 2;
        vec[7].exp_cycle = 6; vec[7].exp_result = 8'd5; vec[7].exp_hs = 2;

        vec[8] = vec[1]; vec[8].start_mid = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset err_code", 32'(err_code), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset dp_op", 32'(dp_op), 32'd0);
        check("reset opnd_ready", 32'(opnd_ready), 32'd0);
        check("reset dp_clr", 32'(dp_clr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // start with zero length must not leave IDLE
        load(vec[0]);
        prog_len = '0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("len0 busy", 32'(busy), 32'd0);
        check("len0 dp_clr", 32'(dp_clr), 32'd0);

        for (int i = 0; i < NV; i++) begin
            load(vec[i]);
            run(vec[i], $sformatf("v%0d", i));
`ifdef STACK_SEQ_DEPTH_CHECK_EN
            if (i == 3) check("v3 pc at trap", 32'(dut.pc), 32'd1);
`endif
        end

        // program writes outside IDLE are dropped: rerun v0 after writing ADD in DONE
        load(vec[0]);
        run(vec[0], "pre_we");
        prog_we = 1'b1; prog_addr = 4'd2; prog_data = OP_ADD;
        @(negedge clk);
        prog_we = 1'b0;
        run(vec[0], "we_in_done");

        // abort mid-RUN, then a full rerun from IDLE
        load(vec[1]);
        prog_len   = 5'd4;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        opnd_valid = 1'b1;
        opnd_data  = 8'hFC;
        @(negedge clk);
        opnd_data  = 8'd6;
        abort      = 1'b1;
        #1;
        check("abort dp_op", 32'(dp_op), 32'(OP_NOP));
        check("abort opnd_ready", 32'(opnd_ready), 32'd0);
        @(negedge clk);
        abort      = 1'b0;
        opnd_valid = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result held", 32'(result), 32'd2);
        @(negedge clk);
        run(vec[1], "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
